// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// State encoding and starvation counter width.
package mem_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int STARVE_CW = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of one single-ported word memory.
// Optional zero-fill after reset, data priority with a starvation cap.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLEAR        = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  input  logic             d_valid,
  input  logic             d_write,
  input  logic [3:0]       d_wmask,
  input  logic [31:0]      d_wdata,
  input  logic [WIDTH-1:0] d_addr,
  output logic             d_ready,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             mem_valid,
  output logic             mem_write,
  output logic [3:0]       mem_wmask,
  output logic [31:0]      mem_wdata,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [31:0]      mem_rdata
);

  localparam logic [STARVE_CW-1:0] SLIM =
    STARVE_CW'(STARVE_LIMIT);
  localparam logic [WIDTH-1:0] CLR_LAST = '1;
  localparam state_t RST_STATE =
    (CLEAR != 0) ? INIT : RUN;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     clr_cnt;
  logic [STARVE_CW-1:0] starve_cnt;
  logic [STARVE_CW-1:0] starve_nxt;
  logic                 grant_d;
  logic                 grant_i;

  // Data wins unless fetch has already waited out its quota.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == RUN) begin
      grant_d = d_valid &
                (~i_valid | (starve_cnt < SLIM));
      grant_i = i_valid & ~grant_d;
    end
  end

  // Next state, starvation count and memory port drive.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_wmask  = d_wmask;
    mem_wdata  = d_wdata;
    mem_addr   = d_addr;
    unique case (state)
      INIT: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_wmask = 4'hF;
        mem_wdata = '0;
        mem_addr  = clr_cnt;
        if (clr_cnt == CLR_LAST)
          state_nxt = RUN;
      end
      RUN: begin
        mem_valid = grant_d | grant_i;
        mem_write = grant_d & d_write;
        if (grant_i)
          mem_addr = i_addr;
        if (grant_i | ~i_valid)
          starve_nxt = '0;
        else if (grant_d && starve_cnt < SLIM)
          starve_nxt = starve_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // State, fill pointer, starvation count, response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_STATE;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (state == INIT)
        clr_cnt <= clr_cnt + 1'b1;
      i_rvalid <= grant_i;
      d_rvalid <= grant_d & ~d_write;
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory.
// Directed table, contention, random model and reset-in-fill tests.
module tb_mem_arbiter;

  localparam int W   = 4;
  localparam int N   = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [W-1:0]  i_addr;
  logic          i_ready;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_valid;
  logic          d_write;
  logic [3:0]    d_wmask;
  logic [31:0]   d_wdata;
  logic [W-1:0]  d_addr;
  logic          d_ready;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_valid;
  logic          mem_write;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [W-1:0]  mem_addr;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .WIDTH(W), .CLEAR(1), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr),
    .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata),
    .d_valid(d_valid), .d_write(d_write),
    .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_addr(d_addr), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // single-ported memory, registered read
  logic [31:0] mem [N];
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b])
            mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic idle();
    i_valid = 1'b0; i_addr  = '0;
    d_valid = 1'b0; d_write = 1'b0;
    d_wmask = '0;   d_wdata = '0; d_addr = '0;
  endtask

  // called at a negedge with rst just released
  task automatic init_walk();
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("init_valid", 32'(mem_valid), 32'd1);
      chk("init_write", 32'(mem_write), 32'd1);
      chk("init_addr", 32'(mem_addr), 32'(k));
      chk("init_wdata", mem_wdata, 32'd0);
      chk("init_wmask", 32'(mem_wmask), 32'hF);
      chk("init_ready", 32'({i_ready, d_ready}), 32'd0);
    end
  endtask

  function automatic logic [31:0] apply_mask(
    input logic [31:0] old, input logic [31:0] nw,
    input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic        iv;
    logic [W-1:0] ia;
    logic        dv;
    logic        dw;
    logic [3:0]  dm;
    logic [31:0] dd;
    logic [W-1:0] da;
    logic        e_ir;
    logic        e_dr;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input int ia, input logic dv,
    input logic dw, input logic [3:0] dm,
    input logic [31:0] dd, input int da,
    input logic e_ir, input logic e_dr,
    input logic e_irv, input logic e_drv,
    input logic [31:0] e_rd);
    vec_t v;
    v.iv = iv; v.ia = W'(ia); v.dv = dv; v.dw = dw;
    v.dm = dm; v.dd = dd; v.da = W'(da);
    v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_irv = e_irv; v.e_drv = e_drv; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t tbl [13];

  logic [31:0] ref_mem [N];
  int          dwins;
  logic        egd, egi;
  logic        exp_irv, exp_drv;
  logic [31:0] exp_id, exp_dd;
  logic        hold_i, hold_d;
  logic        pi;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0,0,1,1,4'hF,32'hA0A0A0A0,0, 0,1,0,0,0);
    tbl[1]  = mk(0,0,1,1,4'hF,32'hB1B1B1B1,1, 0,1,0,0,0);
    tbl[2]  = mk(0,0,1,1,4'hF,32'hC2C2C2C2,2, 0,1,0,0,0);
    tbl[3]  = mk(0,0,1,1,4'hF,32'hDEADBEEF,3, 0,1,0,0,0);
    tbl[4]  = mk(0,0,1,0,4'h0,32'h0,3,        0,1,0,0,0);
    tbl[5]  = mk(0,0,0,0,4'h0,32'h0,0,
                 0,0,0,1,32'hDEADBEEF);
    tbl[6]  = mk(0,0,1,1,4'b0101,32'h11223344,3,
                 0,1,0,0,0);
    tbl[7]  = mk(0,0,1,0,4'h0,32'h0,3,        0,1,0,0,0);
    tbl[8]  = mk(0,0,0,0,4'h0,32'h0,0,
                 0,0,0,1,32'hDE22BE44);
    tbl[9]  = mk(1,0,0,0,4'h0,32'h0,0,        1,0,0,0,0);
    tbl[10] = mk(1,1,0,0,4'h0,32'h0,0,
                 1,0,1,0,32'hA0A0A0A0);
    tbl[11] = mk(1,2,0,0,4'h0,32'h0,0,
                 1,0,1,0,32'hB1B1B1B1);
    tbl[12] = mk(0,0,0,0,4'h0,32'h0,0,
                 0,0,1,0,32'hC2C2C2C2);

    // reset and zero-fill, fetch held high during fill
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_ready", 32'({i_ready, d_ready}), 32'd0);
    i_valid = 1'b1;
    i_addr  = 4'd7;
    @(negedge clk);
    rst = 1'b0;
    init_walk();
    @(negedge clk);
    #1;
    chk("post_init_i_ready", 32'(i_ready), 32'd1);
    chk("post_init_write", 32'(mem_write), 32'd0);
    chk("post_init_addr", 32'(mem_addr), 32'd7);
    @(negedge clk);
    idle();
    #1;
    chk("fetch7_rvalid", 32'(i_rvalid), 32'd1);
    chk("fetch7_rdata", i_rdata, 32'd0);

    // directed table
    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      i_valid = tbl[r].iv; i_addr  = tbl[r].ia;
      d_valid = tbl[r].dv; d_write = tbl[r].dw;
      d_wmask = tbl[r].dm; d_wdata = tbl[r].dd;
      d_addr  = tbl[r].da;
      #1;
      chk($sformatf("tbl%0d_i_ready", r),
          32'(i_ready), 32'(tbl[r].e_ir));
      chk($sformatf("tbl%0d_d_ready", r),
          32'(d_ready), 32'(tbl[r].e_dr));
      chk($sformatf("tbl%0d_i_rvalid", r),
          32'(i_rvalid), 32'(tbl[r].e_irv));
      chk($sformatf("tbl%0d_d_rvalid", r),
          32'(d_rvalid), 32'(tbl[r].e_drv));
      if (tbl[r].e_irv)
        chk($sformatf("tbl%0d_i_rdata", r),
            i_rdata, tbl[r].e_rd);
      if (tbl[r].e_drv)
        chk($sformatf("tbl%0d_d_rdata", r),
            d_rdata, tbl[r].e_rd);
    end

    // contention: D,D,D,D,I repeating
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_valid = 1'b1; i_addr = 4'd5;
      d_valid = 1'b1; d_write = 1'b0; d_addr = 4'd3;
      #1;
      chk($sformatf("cont%0d_d_ready", c),
          32'(d_ready), 32'((c % 5) != 4));
      chk($sformatf("cont%0d_i_ready", c),
          32'(i_ready), 32'((c % 5) == 4));
      if (c > 0) begin
        pi = ((c - 1) % 5) == 4;
        chk($sformatf("cont%0d_i_rvalid", c),
            32'(i_rvalid), 32'(pi));
        chk($sformatf("cont%0d_d_rvalid", c),
            32'(d_rvalid), 32'(!pi));
        if (pi)
          chk("cont_i_rdata", i_rdata, 32'd0);
        else
          chk("cont_d_rdata", d_rdata, 32'hDE22BE44);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("cont_last_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("cont_last_d_rvalid", 32'(d_rvalid), 32'd0);

    // randomized traffic against the reference model
    for (int a = 0; a < N; a++) ref_mem[a] = '0;
    ref_mem[0] = 32'hA0A0A0A0;
    ref_mem[1] = 32'hB1B1B1B1;
    ref_mem[2] = 32'hC2C2C2C2;
    ref_mem[3] = 32'hDE22BE44;
    dwins   = 0;
    exp_irv = 1'b0; exp_drv = 1'b0;
    exp_id  = '0;   exp_dd  = '0;
    hold_i  = 1'b0; hold_d  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!hold_i) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_addr  = W'($urandom_range(0, N - 1));
      end
      if (!hold_d) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_write = 1'($urandom_range(0, 1));
        d_wmask = 4'($urandom);
        d_wdata = $urandom;
        d_addr  = W'($urandom_range(0, N - 1));
      end
      #1;
      egd = d_valid && (!i_valid || dwins < LIM);
      egi = i_valid && !egd;
      chk("rnd_d_ready", 32'(d_ready), 32'(egd));
      chk("rnd_i_ready", 32'(i_ready), 32'(egi));
      chk("rnd_mem_valid", 32'(mem_valid), 32'(egd | egi));
      if (egi) begin
        chk("rnd_i_addr", 32'(mem_addr), 32'(i_addr));
        chk("rnd_i_write", 32'(mem_write), 32'd0);
      end
      if (egd) begin
        chk("rnd_d_addr", 32'(mem_addr), 32'(d_addr));
        chk("rnd_d_write", 32'(mem_write), 32'(d_write));
      end
      chk("rnd_i_rvalid", 32'(i_rvalid), 32'(exp_irv));
      chk("rnd_d_rvalid", 32'(d_rvalid), 32'(exp_drv));
      if (exp_irv) chk("rnd_i_rdata", i_rdata, exp_id);
      if (exp_drv) chk("rnd_d_rdata", d_rdata, exp_dd);
      exp_irv = egi;
      exp_id  = ref_mem[i_addr];
      exp_drv = egd && !d_write;
      exp_dd  = ref_mem[d_addr];
      if (egd && d_write)
        ref_mem[d_addr] = apply_mask(ref_mem[d_addr],
                                     d_wdata, d_wmask);
      if (!i_valid || egi) dwins = 0;
      else if (egd) dwins++;
      hold_i = i_valid && !egi;
      hold_d = d_valid && !egd;
    end
    @(negedge clk);
    idle();
    #1;
    chk("rnd_end_i_rvalid", 32'(i_rvalid), 32'(exp_irv));
    chk("rnd_end_d_rvalid", 32'(d_rvalid), 32'(exp_drv));
    if (exp_irv) chk("rnd_end_i_rdata", i_rdata, exp_id);
    if (exp_drv) chk("rnd_end_d_rdata", d_rdata, exp_dd);

    // reset kills a pending response, then pulse mid-fill
    @(negedge clk);
    i_valid = 1'b1; i_addr = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("rst_clears_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_clears_d_rvalid", 32'(d_rvalid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("fill1_addr", 32'(mem_addr), 32'(k));
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("fill_restart_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    init_walk();
    @(negedge clk);
    d_valid = 1'b1; d_write = 1'b0; d_addr = 4'd3;
    #1;
    chk("refill_d_ready", 32'(d_ready), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("refill_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("refill_d_rdata", d_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
